// File: rtl/ring_step_gen.sv
// ---------------------------------------------------------------------------
// ring_step_gen
//
// Control front-end for a 4-LED ring counter. Two raw board switches are
// conditioned into clean, single-cycle commands for the counter:
//   o_load - preset the ring counter to its one-hot seed
//   o_step - clock enable: advance the ring one position
//
// Each switch channel is: 2-flop synchroniser -> debounce counter ->
// registered rising-edge detector. Load and step channels are identical and
// independent; load wins when both fire in the same cycle.
//
// Optional build feature (macro RING_AUTO_STEP_EN):
//   A step press toggles a free-running auto-step mode (o_run). While running,
//   a prescaler emits one o_step every TICK_DIV cycles. A load press restarts
//   the prescaler spacing from zero. Without the macro, o_run is tied low and
//   no prescaler logic exists.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles a new input level must persist before it is
//                     accepted (>= 2)
//   TICK_DIV        : auto-step period in clk cycles (>= 2); used only with
//                     RING_AUTO_STEP_EN
//
// Ports
//   clk        in  system clock, all logic on the rising edge
//   rst        in  synchronous active-high reset
//   i_sw_load  in  raw asynchronous load switch, active-high
//   i_sw_step  in  raw asynchronous step switch, active-high
//   o_load     out one-cycle preset pulse
//   o_step     out one-cycle advance pulse (never coincident with o_load)
//   o_run      out auto-step mode active (0 without RING_AUTO_STEP_EN)
// ---------------------------------------------------------------------------
module ring_step_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 3000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw_load,
  input  logic i_sw_step,
  output logic o_load,
  output logic o_step,
  output logic o_run
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard on the parameter ranges.
  if (DEBOUNCE_CYCLES < 2 || TICK_DIV < 2) begin : g_bad_param
    $error("ring_step_gen: DEBOUNCE_CYCLES and TICK_DIV must both be >= 2");
  end

  // Channel 0 = load, channel 1 = step.
  logic [1:0] raw;
  logic [1:0] rise;

  assign raw = {i_sw_step, i_sw_load};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          s1_reg;
      logic          s2_reg;
      logic          stable_reg;
      logic          rise_reg;
      logic [CW-1:0] cnt_reg;
      logic          accept;

      // The synchronised level has disagreed with the accepted level for
      // DEBOUNCE_CYCLES consecutive cycles: take it on this edge.
      assign accept = (s2_reg != stable_reg) && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          rise_reg   <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          // Registered alongside the stable flip so the pulse appears in the
          // same cycle the new level becomes visible.
          rise_reg <= accept & s2_reg;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (accept) begin
            stable_reg <= s2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign rise[gi] = rise_reg;
    end
  endgenerate

  logic load_rise;
  logic step_rise;

  assign load_rise = rise[0];
  assign step_rise = rise[1];
  assign o_load    = load_rise;

`ifdef RING_AUTO_STEP_EN
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

  logic          run_reg;
  logic          run_next;
  logic [PW-1:0] pcnt_reg;
  logic [PW-1:0] pcnt_next;
  logic          tick_reg;
  logic          tick_next;

  always_comb begin
    run_next  = run_reg ^ step_rise;
    pcnt_next = pcnt_reg;
    tick_next = 1'b0;
    // Hold the prescaler at 0 while idle, on the entry edge (so the first
    // tick lands a full period after o_run rises), on the exit edge, and
    // whenever a load press restarts the spacing.
    if (load_rise || !run_reg || !run_next) begin
      pcnt_next = '0;
    end else if (pcnt_reg == PCNT_LAST) begin
      pcnt_next = '0;
      tick_next = 1'b1;
    end else begin
      pcnt_next = pcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg  <= 1'b0;
      pcnt_reg <= '0;
      tick_reg <= 1'b0;
    end else begin
      run_reg  <= run_next;
      pcnt_reg <= pcnt_next;
      tick_reg <= tick_next;
    end
  end

  // Load owns any cycle it pulses in; a coincident tick is dropped.
  assign o_step = tick_reg & ~load_rise;
  assign o_run  = run_reg;
`else
  // Load has priority: a step rising in the same cycle is dropped.
  assign o_step = step_rise & ~load_rise;
  assign o_run  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_step_gen.sv
// Directed bench for ring_step_gen (DEBOUNCE_CYCLES=4, TICK_DIV=5).
// Stimulus pushes expected pulses (kind, cycle) into a queue; a monitor on
// the falling edge pops and compares whenever o_load or o_step is high.
// Cycle numbering: cyc = number of rising edges seen so far. A switch driven
// just after edge N is first sampled at edge N+1 and its pulse is visible
// during cyc N+6.
module tb_ring_step_gen;

  localparam int DC = 4;
  localparam int TD = 5;
  localparam int K_LOAD = 1;
  localparam int K_STEP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_load = 1'b0;
  logic sw_step = 1'b0;
  logic o_load;
  logic o_step;
  logic o_run;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];

  ring_step_gen #(
    .DEBOUNCE_CYCLES(DC),
    .TICK_DIV       (TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_sw_load(sw_load),
    .i_sw_step(sw_step),
    .o_load   (o_load),
    .o_step   (o_step),
    .o_run    (o_run)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_load"}, int'(o_load), 0);
    chk({tag, "_step"}, int'(o_step), 0);
    chk({tag, "_run"},  int'(o_run),  0);
  endtask

  // Monitor: one line per observed pulse, compared against the queue head.
  always @(negedge clk) begin
    int k;
    ev_t e;
    if (mon_en && (o_load || o_step)) begin
      k = int'({o_step, o_load});
      $display("pulse kind=%0d cyc=%0d run=%0d", k, cyc, o_run);
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", k, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;

    // 1. Reset held 3 edges with switches high; one load pulse 6 edges later.
    sw_load = 1'b1;
`ifdef RING_AUTO_STEP_EN
    sw_step = 1'b0;
`else
    sw_step = 1'b1;
`endif
    tick(1);
    mon_en = 1'b1;
    chk_idle("rst1_a");
    tick(1);
    chk_idle("rst1_b");
    tick(1);
    chk_idle("rst1_c");
    n = cyc;
    rst = 1'b0;
    push(K_LOAD, n + 6);
    tick(12);
    sw_load = 1'b0;
    sw_step = 1'b0;
    tick(10);

    // 2. Load press held long: one pulse, nothing on hold or release.
    n = cyc;
    sw_load = 1'b1;
    push(K_LOAD, n + 6);
    tick(15);
    sw_load = 1'b0;
    tick(10);

`ifndef RING_AUTO_STEP_EN
    // 3. 3-cycle glitch filtered, then an 8-cycle press gives one step.
    sw_step = 1'b1;
    tick(3);
    sw_step = 1'b0;
    tick(10);
    n = cyc;
    sw_step = 1'b1;
    push(K_STEP, n + 6);
    tick(8);
    sw_step = 1'b0;
    tick(10);

    // 4. Both rise together: load only, step dropped.
    n = cyc;
    sw_load = 1'b1;
    sw_step = 1'b1;
    push(K_LOAD, n + 6);
    tick(10);
    sw_load = 1'b0;
    sw_step = 1'b0;
    tick(10);
`else
    // 5. Auto-step: run on, steps every TD, load restarts spacing, run off.
    n = cyc;
    sw_step = 1'b1;
    push(K_STEP, n + 12);
    push(K_STEP, n + 17);
    push(K_STEP, n + 22);
    tick(6);
    chk("run_before", int'(o_run), 0);
    tick(1);
    chk("run_on", int'(o_run), 1);
    tick(1);
    sw_step = 1'b0;
    tick(11);
    sw_load = 1'b1;
    push(K_LOAD, n + 25);
    push(K_STEP, n + 31);
    push(K_STEP, n + 36);
    tick(8);
    sw_load = 1'b0;
    tick(6);
    sw_step = 1'b1;
    tick(6);
    chk("run_still_on", int'(o_run), 1);
    tick(1);
    chk("run_off", int'(o_run), 0);
    tick(8);
    sw_step = 1'b0;
    tick(12);
`endif

    // 6. Reset mid-debounce (count 2) discards it; fresh debounce after release.
    sw_load = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_idle("rst6_a");
    tick(1);
    chk_idle("rst6_b");
    n = cyc;
    rst = 1'b0;
    push(K_LOAD, n + 6);
    tick(12);
    sw_load = 1'b0;
    tick(10);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
